// File: rtl/sram_frame_scheduler.sv
// Double-buffered frame scheduler in front of an SRAM image controller.
// Capture requests fill the two frame buffers in ring order, and readout
// requests drain them in the same order. Reads win when both are eligible.
// A watchdog aborts any transfer whose done pulse never arrives.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transfer granted; arbitrates pending capture/readout
// WRITE  | write_image_en high, controller filling buffer at wr_ptr
// READ   | read_image_en high, controller draining buffer at rd_ptr
module sram_frame_scheduler #(
    parameter logic [22:0] IMAGE_SIZE = 23'd64,
    parameter logic [12:0] BUF0_ADDR  = 13'd0,
    parameter logic [12:0] BUF1_ADDR  = 13'd4,
    parameter logic [15:0] TIMEOUT    = 16'd1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        capture_req,
    input  logic        readout_req,
    input  logic        write_image_done,
    input  logic        read_image_done,
    output logic [22:0] image_size,
    output logic [12:0] image_start_addr,
    output logic        write_image_en,
    output logic        read_image_en,
    output logic [1:0]  frame_count,
    output logic        busy,
    output logic        frame_dropped,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t      state;
    logic        cap_pend;
    logic        rd_pend;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  full;
    logic [15:0] watchdog;

    logic        read_go;
    logic        write_go;
    logic        drop_go;
    logic        wd_expired;
    logic [12:0] wr_addr;
    logic [12:0] rd_addr;

    assign image_size  = IMAGE_SIZE;
    assign frame_count = {1'b0, full[0]} + {1'b0, full[1]};
    assign busy        = (state != ST_IDLE);

    // Arbitration in IDLE: a readable frame beats a capture; a capture with
    // no free buffer is dropped instead of waiting. Because the buffers form
    // a ring, full[wr_ptr] set means both buffers hold frames.
    always_comb begin
        read_go    = (state == ST_IDLE) && rd_pend && full[rd_ptr];
        write_go   = (state == ST_IDLE) && !read_go && cap_pend && !full[wr_ptr];
        drop_go    = (state == ST_IDLE) && !read_go && cap_pend && full[wr_ptr];
        wd_expired = (watchdog == (TIMEOUT - 16'd1));
        wr_addr    = wr_ptr ? BUF1_ADDR : BUF0_ADDR;
        rd_addr    = rd_ptr ? BUF1_ADDR : BUF0_ADDR;
    end

    // Pending request flags: a new pulse always wins over the clear, so a
    // request landing on the grant edge is kept for the next round.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_pend <= 1'b0;
            rd_pend  <= 1'b0;
        end else begin
            if (capture_req)
                cap_pend <= 1'b1;
            else if (write_go || drop_go)
                cap_pend <= 1'b0;

            if (readout_req)
                rd_pend <= 1'b1;
            else if (read_go)
                rd_pend <= 1'b0;
        end
    end

    // Transfer FSM with registered grants, buffer bookkeeping and watchdog.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            wr_ptr           <= 1'b0;
            rd_ptr           <= 1'b0;
            full             <= 2'b00;
            watchdog         <= 16'd0;
            write_image_en   <= 1'b0;
            read_image_en    <= 1'b0;
            image_start_addr <= BUF0_ADDR;
            frame_dropped    <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            frame_dropped <= 1'b0;
            timeout_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (read_go) begin
                        state            <= ST_READ;
                        read_image_en    <= 1'b1;
                        image_start_addr <= rd_addr;
                        watchdog         <= 16'd0;
                    end else if (write_go) begin
                        state            <= ST_WRITE;
                        write_image_en   <= 1'b1;
                        image_start_addr <= wr_addr;
                        watchdog         <= 16'd0;
                    end else if (drop_go) begin
                        frame_dropped    <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (write_image_done) begin
                        full[wr_ptr]   <= 1'b1;
                        wr_ptr         <= ~wr_ptr;
                        state          <= ST_IDLE;
                        write_image_en <= 1'b0;
                    end else if (wd_expired) begin
                        state          <= ST_IDLE;
                        write_image_en <= 1'b0;
                        timeout_err    <= 1'b1;
                    end else begin
                        watchdog       <= watchdog + 16'd1;
                    end
                end
                ST_READ: begin
                    if (read_image_done) begin
                        full[rd_ptr]  <= 1'b0;
                        rd_ptr        <= ~rd_ptr;
                        state         <= ST_IDLE;
                        read_image_en <= 1'b0;
                    end else if (wd_expired) begin
                        state         <= ST_IDLE;
                        read_image_en <= 1'b0;
                        timeout_err   <= 1'b1;
                    end else begin
                        watchdog      <= watchdog + 16'd1;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    write_image_en <= 1'b0;
                    read_image_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_frame_scheduler.md
SRAM_FRAME_SCHEDULER -- requirements
Module: sram_frame_scheduler

Interface
REQ-001 The block SHALL have parameter IMAGE_SIZE, default 23'd64, meaning pixels per frame (2 bits each).
REQ-002 The block SHALL have parameter BUF0_ADDR, default 13'd0, meaning SRAM word start address of buffer 0.
REQ-003 The block SHALL have parameter BUF1_ADDR, default 13'd4, meaning SRAM word start address of buffer 1.
REQ-004 The block SHALL have parameter TIMEOUT, default 16'd1024, meaning maximum cycles from grant to done.
REQ-005 The block SHALL have port clock, input, 1, meaning the single clock; all logic SHALL be rising-edge.
REQ-006 The block SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-007 The block SHALL have port capture_req, input, 1, meaning one-cycle pulse requesting a frame write.
REQ-008 The block SHALL have port readout_req, input, 1, meaning one-cycle pulse requesting a frame read.
REQ-009 The block SHALL have port write_image_done, input, 1, meaning controller write-complete pulse.
REQ-010 The block SHALL have port read_image_done, input, 1, meaning controller read-complete pulse.
REQ-011 The block SHALL have port image_size, output, 23, meaning constant IMAGE_SIZE to the controller.
REQ-012 The block SHALL have port image_start_addr, output, 13, meaning active buffer address.
REQ-013 The block SHALL have port write_image_en, output, 1, meaning write grant to the controller.
REQ-014 The block SHALL have port read_image_en, output, 1, meaning read grant to the controller.
REQ-015 The block SHALL have port frame_count, output, 2, meaning full buffers (0..2).
REQ-016 The block SHALL have port busy, output, 1, meaning FSM not in IDLE.
REQ-017 The block SHALL have port frame_dropped, output, 1, meaning one-cycle pulse: capture refused, both buffers full.
REQ-018 The block SHALL have port timeout_err, output, 1, meaning one-cycle pulse: done not seen within TIMEOUT.

Function
REQ-019 The block SHALL keep two-deep FIFO state: wr_ptr, rd_ptr (1 bit each), full[1:0]; frame_count = full[0]+full[1].
REQ-020 A capture_req or readout_req pulse SHALL set the matching pending flag at that edge; repeat pulses while pending SHALL merge.
REQ-021 The FSM SHALL have states IDLE, WRITE, READ.
REQ-022 In IDLE, if read pending and full[rd_ptr], the FSM SHALL enter READ (read wins when both qualify).
REQ-023 Else, in IDLE, if capture pending and !full[wr_ptr], the FSM SHALL enter WRITE.
REQ-024 Else, in IDLE, if capture pending and both buffers full, capture pending SHALL clear and frame_dropped SHALL pulse once.
REQ-025 A read pending with frame_count 0 SHALL stay pending until a frame completes.
REQ-026 The grant edge SHALL clear the served pending flag; a request pulse arriving at the grant edge SHALL re-set the flag.
REQ-027 Latency SHALL be: request pulse sampled at edge k; enable high after edge k+1 when IDLE and qualified.
REQ-028 In WRITE, write_image_en SHALL be 1 and image_start_addr SHALL be BUFx_ADDR selected by wr_ptr, stable throughout.
REQ-029 In READ, read_image_en SHALL be 1 and image_start_addr SHALL be BUFx_ADDR selected by rd_ptr, stable throughout.
REQ-030 write_image_done in WRITE SHALL set full[wr_ptr], toggle wr_ptr and return to IDLE; the enable SHALL be low the next cycle.
REQ-031 read_image_done in READ SHALL clear full[rd_ptr], toggle rd_ptr and return to IDLE.
REQ-032 Done pulses outside the matching state SHALL be ignored.
REQ-033 A 16-bit watchdog SHALL clear on grant and increment in WRITE/READ.
REQ-034 On reaching TIMEOUT, the FSM SHALL return to IDLE, pulse timeout_err and leave pointers and full flags unchanged.
REQ-035 The FSM SHALL never assert write_image_en and read_image_en together.
REQ-036 Pointer toggles SHALL wrap 1->0.

Reset
REQ-037 Reset SHALL immediately force state IDLE, both enables 0, pending flags 0, pointers 0, full 0, watchdog 0.
REQ-038 Reset SHALL immediately force image_start_addr = BUF0_ADDR, frame_count 0, busy 0, frame_dropped 0, timeout_err 0, including mid-transfer.

Verification
REQ-039 capture_req at edge k -> write_image_en=1 after edge k+1, addr 0; done -> frame_count=1, en low next cycle.
REQ-040 Two captures -> second at addr 4; third capture -> frame_dropped pulse, no enable, frame_count stays 2.
REQ-041 From frame_count=2, capture_req and readout_req same cycle -> read first at addr 0, then write at addr 0.
REQ-042 readout_req with frame_count 0 -> no enable; after capture completes -> read_image_en at addr 0.
REQ-043 Grant with done withheld 1024 cycles -> timeout_err pulse, IDLE, frame_count unchanged.
REQ-044 Reset asserted mid-WRITE -> en 0 in the same cycle, all outputs at reset values.
